truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Sequencing controller for a 3-input combinational logic-gate datapath (in1, in2, in3 -> out).
- On command, drives all 8 input combinations in order and waits a programmable settle time per vector.
- Samples the gate output and assembles the measured 8-bit truth table.
- Compares the measured table against an expected table. Used as the on-chip characterisation and self-check engine for the case-defined 3-input gate library.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each input vector is held before the output is sampled; legal range 1..255.
- CNT_W, 8, width of the internal settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  terminates a sweep in progress.
- expected  input  8  expected truth table; latched on an accepted start.
- dut_in  output  3  {in1,in2,in3} drive to the gate under test.
- dut_out  input  1  gate output; synchronous to clk.
- busy  output  1  high from the cycle after an accepted start until the sweep ends.
- done  output  1  one-cycle pulse when results are committed.
- observed  output  8  measured truth table.
- mismatch_mask  output  8  observed XOR expected_latched.
- match  output  1  1 when mismatch_mask == 0.

Behaviour:
- Bit order (library convention): table bit [7-v] holds the output for input vector v = {in1,in2,in3}.
  - Example: 0x97 means 000->1 and 111->1.
- Reset (async, rst_n=0): state IDLE, dut_in=3'b000, busy=0, done=0, observed=8'h00, mismatch_mask=8'h00, match=0, internal index/counter/shadow=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 (abort=0): latch expected, idx=0, dut_in=000, cnt=0, shadow=0, go to SETTLE, busy=1 next cycle.
  - start=1 with abort=1 in the same cycle: abort wins and start is ignored.
- SETTLE: cnt increments each cycle; when cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle):
  - shadow[7-idx] <= dut_out.
  - If idx==7, go to DONE.
  - Otherwise idx++, dut_in <= idx+1, cnt=0, go to SETTLE.
- DONE (one cycle):
  - observed <= shadow; mismatch_mask <= shadow ^ expected_latched; match <= (shadow==expected_latched).
  - done=1, busy=0 from the following cycle, dut_in <= 000, return to IDLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. With start accepted at edge 0, done is high in cycle 8*(SETTLE_CYCLES+1)+1, which is cycle 41 for the default.
- start while busy: ignored, with no effect on idx, cnt or latched expected.
- abort in SETTLE or SAMPLE:
  - Next cycle: IDLE, dut_in=000, busy=0, no done pulse.
  - observed, mismatch_mask and match keep their previous-sweep values; the shadow register is discarded.
- abort in DONE: ignored, because results commit that cycle.
- expected changes mid-sweep: no effect; only the value latched at start is used.
- Results are stable from the done cycle until the next DONE commit; a new start does not clear them.
- Reset asserted mid-sweep: immediate return to reset values, including clearing of the results.
- done and busy are never both high in the same cycle.
- dut_in changes only on SAMPLE->SETTLE transitions, on start, and on exit to IDLE.

Test Plan:
- SETTLE_CYCLES=4, bench gate model = 0x97 function, start with expected=8'h97 -> dut_in steps 000..111 every 5 cycles; done pulses at cycle 41; observed=8'h97, mismatch_mask=8'h00, match=1.
- Same gate, expected=8'h96 -> observed=8'h97, mismatch_mask=8'h01, match=0.
- Gate model output changes 3 cycles after each input change (SETTLE_CYCLES=4) -> still 8'h97. Rerun with SETTLE_CYCLES=2 -> sampled values are stale and match=0.
- Abort at cycle 17 of a sweep that follows a completed 0x97 sweep -> busy=0 at cycle 18, dut_in=000, no done, observed stays 8'h97; a new start later completes normally.
- start pulsed at cycles 10 and 20 during a sweep -> ignored; single done at cycle 41. start+abort together in IDLE -> no sweep.
- rst_n low at cycle 25 mid-sweep -> all outputs immediately at reset values (observed=00, match=0); rst_n high followed by start -> full sweep completes with correct results.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper for a 3-input combinational gate.
// Steps the gate through all eight input vectors {in1,in2,in3} = 000..111.
// Each vector is held for SETTLE_CYCLES cycles, then the gate output is sampled
// for one cycle. The 8-bit table is assembled with bit [7-v] holding the output
// for vector v. The finished table is compared against an expected table that
// is latched when the sweep starts.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] observed,
    output logic [7:0] mismatch_mask,
    output logic       match
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Last settle count before the output is considered stable.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shadow;
    logic [7:0]       expected_latched;

    logic start_ok;
    logic abort_run;

    // Abort wins over start in IDLE. Abort is honoured only while vectors are
    // still being applied, so a sweep that has reached DONE always commits.
    assign start_ok  = (state == S_IDLE) && start && !abort;
    assign abort_run = abort && ((state == S_SETTLE) || (state == S_SAMPLE));

    // Next-state decode for the sweep sequencer.
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:   if (start_ok) state_next = S_SETTLE;
            S_SETTLE: begin
                if (abort_run)               state_next = S_IDLE;
                else if (cnt == SETTLE_LAST) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort_run)        state_next = S_IDLE;
                else if (idx == 3'd7) state_next = S_DONE;
                else                  state_next = S_SETTLE;
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Vector index, settle counter, gate drive and the partial-table shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= '0;
            cnt              <= '0;
            dut_in           <= '0;
            shadow           <= '0;
            expected_latched <= '0;
        end else if (abort_run) begin
            // Abandon the sweep. The partial table is thrown away.
            idx    <= '0;
            cnt    <= '0;
            dut_in <= '0;
            shadow <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        expected_latched <= expected;
                        idx              <= '0;
                        cnt              <= '0;
                        dut_in           <= 3'b000;
                        shadow           <= '0;
                    end
                end
                S_SETTLE: cnt <= cnt + CNT_W'(1);
                S_SAMPLE: begin
                    shadow[3'd7 - idx] <= dut_out;
                    if (idx != 3'd7) begin
                        idx    <= idx + 3'd1;
                        dut_in <= idx + 3'd1;
                        cnt    <= '0;
                    end
                end
                S_DONE:   dut_in <= 3'b000;
                default:  dut_in <= 3'b000;
            endcase
        end
    end

    // Busy spans the sweep. Done pulses for the single cycle after the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (start_ok)
                busy <= 1'b1;
            else if (abort_run || (state == S_DONE))
                busy <= 1'b0;
        end
    end

    // Result registers. They hold their value until the next DONE commit or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            observed      <= '0;
            mismatch_mask <= '0;
            match         <= 1'b0;
        end else if (state == S_DONE) begin
            observed      <= shadow;
            mismatch_mask <= shadow ^ expected_latched;
            match         <= (shadow == expected_latched);
        end
    end

endmodule
